// File: rtl/scan_req_router.sv
// Routes one scan request at a time to SRAM or register bank; scan_ready at ready+1 (min 2 cycles), strobes while busy are dropped.
// Optional watchdog under SCAN_ROUTER_TIMEOUT_EN aborts hung transactions with scan_err and all-ones data.
module scan_req_router #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int SRAM_AW     = 11,
   parameter int CTR_AW      = 4,
   parameter int LANE_W      = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scan_ren,
   input  logic              scan_wen,
   input  logic [ADDR_W-1:0] scan_addr,
   input  logic [DATA_W-1:0] scan_wdata,
   output logic [DATA_W-1:0] scan_rdata,
   output logic              scan_ready,
   output logic              scan_err,
   output logic              scan_busy,
   output logic              sram_ren,
   output logic              sram_wen,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   input  logic              sram_ready,
   output logic              ctr_ren,
   output logic              ctr_wen,
   output logic [CTR_AW-1:0] ctr_addr,
   output logic [DATA_W-1:0] ctr_wdata,
   input  logic [DATA_W-1:0] ctr_rdata,
   input  logic              ctr_ready,
   output logic [LANE_W-1:0] lane_id,
   output logic              id_sel
);

   generate
      if (SRAM_AW > ADDR_W-1 || CTR_AW > ADDR_W-1 || LANE_W > ADDR_W-2 || TIMEOUT_CYC < 2) begin : g_param_err
         $error("scan_req_router: illegal parameter combination");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic wr;
      logic tgt;
   } op_t;

   state_t state, state_nxt;
   op_t    op;

   logic              accept;
   logic              req_tgt;
   logic              tgt_ready;
   logic [DATA_W-1:0] tgt_rdata;
   logic              timeout_hit;

   logic [DATA_W-1:0]  scan_rdata_n;
   logic               scan_ready_n;
   logic               scan_busy_n;
   logic               sram_ren_n;
   logic               sram_wen_n;
   logic [SRAM_AW-1:0] sram_addr_n;
   logic [DATA_W-1:0]  sram_wdata_n;
   logic               ctr_ren_n;
   logic               ctr_wen_n;
   logic [CTR_AW-1:0]  ctr_addr_n;
   logic [DATA_W-1:0]  ctr_wdata_n;
   logic [LANE_W-1:0]  lane_id_n;
   logic               id_sel_n;

   assign accept    = (state == IDLE) && (scan_ren || scan_wen);
   assign req_tgt   = scan_addr[ADDR_W-1];
   assign tgt_ready = op.tgt ? ctr_ready : sram_ready;
   assign tgt_rdata = op.tgt ? ctr_rdata : sram_rdata;

   // Watchdog counts ISSUE+WAIT cycles; the abort decision is made in the last allowed cycle.
`ifdef SCAN_ROUTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= '0;
      end else if (state == ISSUE || state == WAIT) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign timeout_hit = (state == ISSUE || state == WAIT) && !tgt_ready && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_err <= 1'b0;
      end else begin
         scan_err <= timeout_hit;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign scan_err    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ISSUE;
         ISSUE:   state_nxt = (tgt_ready || timeout_hit) ? RESP : WAIT;
         WAIT:    if (tgt_ready || timeout_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op <= '0;
      end else if (accept) begin
         op <= '{wr: scan_wen, tgt: req_tgt};
      end
   end

   // Target-side fields load only on acceptance; the unselected target is zeroed.
   always_comb begin
      scan_ready_n = (state_nxt == RESP);
      scan_busy_n  = (state_nxt != IDLE);
      scan_rdata_n = '0;
      sram_ren_n   = 1'b0;
      sram_wen_n   = 1'b0;
      ctr_ren_n    = 1'b0;
      ctr_wen_n    = 1'b0;
      sram_addr_n  = sram_addr;
      sram_wdata_n = sram_wdata;
      ctr_addr_n   = ctr_addr;
      ctr_wdata_n  = ctr_wdata;
      lane_id_n    = lane_id;
      id_sel_n     = id_sel;

      if (accept) begin
         lane_id_n = scan_addr[LANE_W:1];
         id_sel_n  = scan_addr[0];
         if (req_tgt) begin
            ctr_ren_n    = !scan_wen;
            ctr_wen_n    = scan_wen;
            ctr_addr_n   = scan_addr[CTR_AW-1:0];
            ctr_wdata_n  = scan_wdata;
            sram_addr_n  = '0;
            sram_wdata_n = '0;
         end else begin
            sram_ren_n   = !scan_wen;
            sram_wen_n   = scan_wen;
            sram_addr_n  = scan_addr[ADDR_W-2 -: SRAM_AW];
            sram_wdata_n = scan_wdata;
            ctr_addr_n   = '0;
            ctr_wdata_n  = '0;
         end
      end

      if ((state == ISSUE || state == WAIT) && state_nxt == RESP) begin
         if (timeout_hit) begin
            scan_rdata_n = '1;
         end else if (!op.wr) begin
            scan_rdata_n = tgt_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_rdata <= '0;
         scan_ready <= 1'b0;
         scan_busy  <= 1'b0;
         sram_ren   <= 1'b0;
         sram_wen   <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         ctr_ren    <= 1'b0;
         ctr_wen    <= 1'b0;
         ctr_addr   <= '0;
         ctr_wdata  <= '0;
         lane_id    <= '0;
         id_sel     <= 1'b0;
      end else begin
         scan_rdata <= scan_rdata_n;
         scan_ready <= scan_ready_n;
         scan_busy  <= scan_busy_n;
         sram_ren   <= sram_ren_n;
         sram_wen   <= sram_wen_n;
         sram_addr  <= sram_addr_n;
         sram_wdata <= sram_wdata_n;
         ctr_ren    <= ctr_ren_n;
         ctr_wen    <= ctr_wen_n;
         ctr_addr   <= ctr_addr_n;
         ctr_wdata  <= ctr_wdata_n;
         lane_id    <= lane_id_n;
         id_sel     <= id_sel_n;
      end
   end

endmodule
